// File: rtl/csa_pkg.sv
// Shared definitions for the counter-share arbiter.
//
// Contents:
//   MAX_NREQ       upper bound on the requester count (index width sized for it)
//   IDX_W          width of a requester index
//   csa_state_e    FSM state: IDLE (no grant) / COUNT (interval running)
//   onehot_to_idx  converts a one-hot vector (zero-padded to MAX_NREQ) to its index
//
// Build option used by the files importing this package:
//   CSA_ROUND_ROBIN_EN  round-robin arbitration when defined, fixed priority otherwise.

package csa_pkg;

  localparam int MAX_NREQ = 8;
  localparam int IDX_W    = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } csa_state_e;

  // OR-reduction of the positions of set bits. For a one-hot input this is
  // exactly its index; an all-zero input yields 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/csa_pick.sv
// Combinational winner select for the counter-share arbiter.
//
// Ports:
//   req_i      [NREQ-1:0]   request levels
//   ptr_i      [IDX_W-1:0]  round-robin search start (only with CSA_ROUND_ROBIN_EN)
//   win_oh_o   [NREQ-1:0]   one-hot winner, zero when no request
//   win_idx_o  [IDX_W-1:0]  index of the winner
//   any_o                   at least one request is present
//
// Build option:
//   CSA_ROUND_ROBIN_EN defined   search begins at ptr_i and wraps around
//   CSA_ROUND_ROBIN_EN undefined lowest requesting index wins, no pointer input

module csa_pick
  import csa_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req_i,
`ifdef CSA_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0] ptr_i,
`endif
  output logic [NREQ-1:0]  win_oh_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             any_o
);

  logic                found;
  logic [MAX_NREQ-1:0] oh_pad;

`ifdef CSA_ROUND_ROBIN_EN
  // Two passes: first the indices at or above the pointer, then everything
  // from index 0. The second pass only fires when nothing at/above the pointer
  // requested, which makes it the wrapped-around part of the search.
  always_comb begin
    win_oh_o = '0;
    found    = 1'b0;
    for (int b = 0; b < NREQ; b++) begin
      if (!found && req_i[b] && (IDX_W'(b) >= ptr_i)) begin
        win_oh_o[b] = 1'b1;
        found       = 1'b1;
      end
    end
    for (int b = 0; b < NREQ; b++) begin
      if (!found && req_i[b]) begin
        win_oh_o[b] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win_oh_o = '0;
    found    = 1'b0;
    for (int b = 0; b < NREQ; b++) begin
      if (!found && req_i[b]) begin
        win_oh_o[b] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    oh_pad             = '0;
    oh_pad[NREQ-1:0]   = win_oh_o;
  end

  assign win_idx_o = onehot_to_idx(oh_pad);
  assign any_o     = |req_i;

endmodule

// File: rtl/counter_share_arbiter.sv
// Time-shares one W-bit up-counter among NREQ requesters.
//
// A requester raises its req level and keeps it high until it sees its done
// pulse (or drops it to abort). The arbiter grants the counter to one
// requester, latches that requester's terminal count, counts 0..len_q and
// pulses done for the granted requester in the cycle where count == len_q.
// A grant therefore lasts len_q+1 cycles and is always followed by at least
// one IDLE cycle before the next grant.
//
// Ports:
//   clock   in   1        clock, all logic on posedge
//   reset   in   1        synchronous active-high reset
//   req     in   NREQ     request levels
//   len     in   NREQ*W   terminal counts, slice i = len[i*W +: W]
//   gnt     out  NREQ     one-hot grant (registered)
//   busy    out  1        FSM is in COUNT (direct view of the state register)
//   count   out  W        counter value (registered)
//   done    out  NREQ     one-hot pulse in the terminal cycle of a grant
//
// Build option:
//   CSA_ROUND_ROBIN_EN  round-robin arbitration with a rotating pointer;
//                       without it the lowest requesting index wins.

module counter_share_arbiter
  import csa_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [W-1:0]      count,
  output logic [NREQ-1:0]   done
);

  csa_state_e       state_q;
  logic [NREQ-1:0]  gnt_q;
  logic [W-1:0]     count_q;
  logic [W-1:0]     len_q;

  logic [NREQ-1:0]  win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             any_req;
  logic [W-1:0]     len_sel;
  logic             granted_req;
  logic             at_term;

`ifdef CSA_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // Pointer moves to the index just past the winner, wrapping at NREQ.
  assign ptr_d = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
`endif

  csa_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i     (req),
`ifdef CSA_ROUND_ROBIN_EN
    .ptr_i     (ptr_q),
`endif
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .any_o     (any_req)
  );

  // Terminal count of the current winner, latched only when the grant is made.
  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDX_W'(i)) len_sel = len[i*W +: W];
    end
  end

  // The granted requester still holds its request.
  assign granted_req = |(req & gnt_q);
  assign at_term     = (count_q == len_q);

  // Abort wins over terminal count: done needs req still high, and the
  // FSM below treats a dropped request first.
  assign done  = ((state_q == COUNT) && at_term) ? (gnt_q & req) : '0;
  assign gnt   = gnt_q;
  assign count = count_q;
  assign busy  = (state_q == COUNT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
`ifdef CSA_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          count_q <= '0;
          if (any_req) begin
            state_q <= COUNT;
            gnt_q   <= win_oh;
            len_q   <= len_sel;
`ifdef CSA_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
          end else begin
            gnt_q <= '0;
          end
        end
        COUNT: begin
          if (!granted_req || at_term) begin
            // Abort or interval complete: release the counter.
            state_q <= IDLE;
            gnt_q   <= '0;
            count_q <= '0;
          end else begin
            count_q <= count_q + W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Bench for counter_share_arbiter: directed scenarios push the expected
// per-cycle {gnt, count, done} triples of every busy cycle into exp_q; a
// negedge monitor pops one entry whenever the DUT shows any activity.
// Reset, idle-gap and abort outcomes are checked directly.

module tb_counter_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int EW   = 2*NREQ + W;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] len;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [W-1:0]      count;
  logic [NREQ-1:0]   done;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];

  counter_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .busy  (busy),
    .count (count),
    .done  (done)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_interval(input int k, input int l);
    logic [NREQ-1:0] g;
    g = '0;
    g[k] = 1'b1;
    for (int c = 0; c <= l; c++)
      exp_q.push_back({g, W'(c), (c == l) ? g : {NREQ{1'b0}}});
  endtask

  // Full interval for requester k with terminal count l. Optionally alters
  // len[k] after the grant to show that the latched value is used.
  task automatic grant_once(input int k, input int l, input bit chg_len);
    req = '0;
    req[k] = 1'b1;
    len[k*W +: W] = W'(l);
    push_interval(k, l);
    step();
    if (chg_len) len[k*W +: W] = ~W'(l);
    repeat (l + 1) step();
    req = '0;
    @(negedge clock);
    chk("idle_after_busy", {31'd0, busy}, 32'd0);
    chk("idle_after_gnt", {28'd0, gnt}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    reset = 1'b0;
    @(negedge clock);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (busy || gnt != '0 || done != '0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected: gnt=%b count=%0d done=%b busy=%b", gnt, count, done, busy);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        total++;
        if ({gnt, count, done} !== e || busy !== 1'b1) begin
          bad++;
          $display("FAIL mon_cycle: got gnt=%b count=%0d done=%b busy=%b expected gnt=%b count=%0d done=%b busy=1",
                   gnt, count, done, busy, e[EW-1 -: NREQ], e[NREQ +: W], e[NREQ-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int order[$];
    reset = 1'b1;
    req   = '1;
    len   = '0;

    // 1: reset held with all requests high: everything stays zero.
    repeat (2) begin
      @(negedge clock);
      chk("rst_gnt", {28'd0, gnt}, 32'd0);
      chk("rst_count", {28'd0, count}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {28'd0, done}, 32'd0);
    end
    reset = 1'b0;
    req   = '0;
    @(negedge clock);

    // 2: len=3 on requester 1; len[1] changed mid-grant is ignored.
    grant_once(1, 3, 1'b1);
    // 3: len=0 gives done in the only COUNT cycle.
    grant_once(0, 0, 1'b0);
    // Maximum length: 16 cycles, no wrap.
    grant_once(1, 15, 1'b0);

    // 4: all requesting, all len=1, starting from reset.
    do_reset();
`ifdef CSA_ROUND_ROBIN_EN
    order = '{0, 1, 2, 3, 0};
`else
    order = '{0, 0, 0};
`endif
    for (int i = 0; i < order.size(); i++) push_interval(order[i], 1);
    for (int i = 0; i < NREQ; i++) len[i*W +: W] = W'(1);
    req = '1;
    for (int c = 0; c < 3 * order.size(); c++) begin
      step();
      @(negedge clock);
      chk("share_busy", {31'd0, busy}, (c % 3 != 2) ? 32'd1 : 32'd0);
    end
    req = '0;
    @(negedge clock);
    chk("share_end_busy", {31'd0, busy}, 32'd0);

    // 5: abort at count=2 of len=5.
    req = 4'b0100;
    len[2*W +: W] = W'(5);
    push_interval_prefix(2, 3);
    repeat (3) step();
    req = '0;
    step();
    @(negedge clock);
    chk("abort_gnt", {28'd0, gnt}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_count", {28'd0, count}, 32'd0);

    // Abort in the terminal cycle: no done.
    req = 4'b0001;
    len[0 +: W] = W'(1);
    exp_q.push_back({4'b0001, W'(0), 4'b0000});
    exp_q.push_back({4'b0001, W'(1), 4'b0000});
    repeat (2) step();
    req = '0;
    step();
    @(negedge clock);
    chk("abort_term_busy", {31'd0, busy}, 32'd0);

    // 6: reset at count=2 of len=6 on requester 2.
    req = 4'b0100;
    len[2*W +: W] = W'(6);
    push_interval_prefix(2, 3);
    repeat (3) step();
    reset = 1'b1;
    req   = '0;
    step();
    @(negedge clock);
    chk("midrst_gnt", {28'd0, gnt}, 32'd0);
    chk("midrst_count", {28'd0, count}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {28'd0, done}, 32'd0);
    reset = 1'b0;
    // Pointer back at 0: requesters 1 and 3 compete, 1 must win.
    req = 4'b1010;
    len[1*W +: W] = W'(0);
    len[3*W +: W] = W'(0);
    exp_q.push_back({4'b0010, W'(0), 4'b0010});
    step();
    step();
    req = '0;
    @(negedge clock);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // First n cycles of an interval that will not reach its terminal count.
  task automatic push_interval_prefix(input int k, input int n);
    logic [NREQ-1:0] g;
    g = '0;
    g[k] = 1'b1;
    for (int c = 0; c < n; c++) exp_q.push_back({g, W'(c), {NREQ{1'b0}}});
  endtask

endmodule
